// File: rtl/el2_ahb_master_arbiter_if.sv
// AHB-Lite address/data-phase bundle. The arbiter faces each CPU-side master
// through the slave modport and drives the SoC bus through the master modport.
interface el2_ahb_master_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] HADDR;
  logic [2:0]    HSIZE;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  modport master (output HADDR, HSIZE, HTRANS, HWRITE, HWDATA,
                  input  HRDATA, HREADY, HRESP);
  modport slave  (input  HADDR, HSIZE, HTRANS, HWRITE, HWDATA,
                  output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/el2_ahb_master_arbiter.sv
// Two-master (IFU/LSU) AHB-Lite arbiter: per-master address-phase hold,
// combinational grant frozen during wait states, data-phase owner steering.
module el2_ahb_master_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int PRIO_MODE  = 1,
  parameter int BURST_LOCK = 1
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  el2_ahb_master_arbiter_if.slave  ifu,
  el2_ahb_master_arbiter_if.slave  lsu,
  el2_ahb_master_arbiter_if.master bus
);
  localparam int         NUM_M = 2;
  localparam logic       IFU   = 1'b0;
  localparam logic       LSU   = 1'b1;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SEQ   = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [1:0]    trans;
    logic          write;
  } aph_t;

  aph_t [NUM_M-1:0]          live, hold_q, cur;
  logic [NUM_M-1:0][DW-1:0]  wdata;
  logic [NUM_M-1:0]          pend_q, rdy_out, req, cap, rel;
  logic                      gnt, gnt_q, rr_last_q;
  logic                      dvld_q, down_q;  // data-phase owner: valid + master id

  assign live[IFU] = '{addr: ifu.HADDR, size: ifu.HSIZE, trans: ifu.HTRANS, write: ifu.HWRITE};
  assign live[LSU] = '{addr: lsu.HADDR, size: lsu.HSIZE, trans: lsu.HTRANS, write: lsu.HWRITE};
  assign wdata     = {lsu.HWDATA, ifu.HWDATA};

  // A master is stalled while its transfer sits in the hold register, and
  // otherwise sees bus HREADY only while it owns the data phase.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      rdy_out[m] = !HRESETn || (!pend_q[m] && (!(dvld_q && down_q == 1'(m)) || bus.HREADY));
      cur[m]     = pend_q[m] ? hold_q[m] : live[m];
      req[m]     = HRESETn && (pend_q[m] || (live[m].trans[1] && rdy_out[m]));
    end
  end

  always_comb begin
    gnt = gnt_q;
    if (bus.HREADY) begin
      if ((BURST_LOCK != 0) && req[gnt_q] && cur[gnt_q].trans == SEQ) gnt = gnt_q;
      else if (req[LSU] && req[IFU]) gnt = (PRIO_MODE != 0) ? LSU : ~rr_last_q;
      else if (req[LSU])             gnt = LSU;
      else if (req[IFU])             gnt = IFU;
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      cap[m] = live[m].trans[1] && rdy_out[m] && !(gnt == 1'(m) && bus.HREADY);
      rel[m] = pend_q[m] && gnt == 1'(m) && bus.HREADY;
    end
  end

  always_comb begin
    bus.HADDR  = '0;
    bus.HSIZE  = '0;
    bus.HTRANS = IDLE;
    bus.HWRITE = 1'b0;
    if (req[gnt]) begin
      bus.HADDR  = cur[gnt].addr;
      bus.HSIZE  = cur[gnt].size;
      bus.HTRANS = cur[gnt].trans;
      bus.HWRITE = cur[gnt].write;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_q    <= '0;
      hold_q    <= '0;
      gnt_q     <= IFU;
      rr_last_q <= LSU;
      dvld_q    <= 1'b0;
      down_q    <= IFU;
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        if (cap[m]) begin
          pend_q[m] <= 1'b1;
          hold_q[m] <= live[m];
        end else if (rel[m]) begin
          pend_q[m] <= 1'b0;
        end
      end
      gnt_q <= gnt;
      if (bus.HREADY) begin
        dvld_q <= bus.HTRANS[1];
        if (bus.HTRANS[1]) begin
          down_q    <= gnt;
          rr_last_q <= gnt;
        end
      end
    end
  end

  assign bus.HWDATA = dvld_q ? wdata[down_q] : '0;
  assign ifu.HRDATA = bus.HRDATA;
  assign lsu.HRDATA = bus.HRDATA;
  assign ifu.HREADY = rdy_out[IFU];
  assign lsu.HREADY = rdy_out[LSU];
  assign ifu.HRESP  = HRESETn && dvld_q && (down_q == IFU) && bus.HRESP;
  assign lsu.HRESP  = HRESETn && dvld_q && (down_q == LSU) && bus.HRESP;
endmodule

// File: tb/tb_el2_ahb_master_arbiter.sv
// Bench for el2_ahb_master_arbiter: fixed-priority (g_dut[0]) and round-robin
// (g_dut[1]) instances, directed steps plus scoreboarded random traffic.
module tb_el2_ahb_master_arbiter;
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  // [dut][master], master 0 = IFU, 1 = LSU
  logic [1:0][1:0][31:0] m_addr, m_wdata, o_rdata;
  logic [1:0][1:0][2:0]  m_size;
  logic [1:0][1:0][1:0]  m_trans;
  logic [1:0][1:0]       m_write, o_rdy, o_resp;
  logic [1:0][31:0]      b_addr, b_wdata, b_rdata;
  logic [1:0][2:0]       b_size;
  logic [1:0][1:0]       b_trans;
  logic [1:0]            b_write, b_ready, b_resp;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    el2_ahb_master_arbiter_if ifu_if ();
    el2_ahb_master_arbiter_if lsu_if ();
    el2_ahb_master_arbiter_if bus_if ();
    assign ifu_if.HADDR  = m_addr[d][0];
    assign ifu_if.HSIZE  = m_size[d][0];
    assign ifu_if.HTRANS = m_trans[d][0];
    assign ifu_if.HWRITE = m_write[d][0];
    assign ifu_if.HWDATA = m_wdata[d][0];
    assign lsu_if.HADDR  = m_addr[d][1];
    assign lsu_if.HSIZE  = m_size[d][1];
    assign lsu_if.HTRANS = m_trans[d][1];
    assign lsu_if.HWRITE = m_write[d][1];
    assign lsu_if.HWDATA = m_wdata[d][1];
    assign o_rdata[d][0] = ifu_if.HRDATA;
    assign o_rdy[d][0]   = ifu_if.HREADY;
    assign o_resp[d][0]  = ifu_if.HRESP;
    assign o_rdata[d][1] = lsu_if.HRDATA;
    assign o_rdy[d][1]   = lsu_if.HREADY;
    assign o_resp[d][1]  = lsu_if.HRESP;
    assign b_addr[d]     = bus_if.HADDR;
    assign b_size[d]     = bus_if.HSIZE;
    assign b_trans[d]    = bus_if.HTRANS;
    assign b_write[d]    = bus_if.HWRITE;
    assign b_wdata[d]    = bus_if.HWDATA;
    assign bus_if.HRDATA = b_rdata[d];
    assign bus_if.HREADY = b_ready[d];
    assign bus_if.HRESP  = b_resp[d];

    el2_ahb_master_arbiter #(
      .AW(32), .DW(32), .PRIO_MODE(d == 0 ? 1 : 0), .BURST_LOCK(1)
    ) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .ifu(ifu_if), .lsu(lsu_if), .bus(bus_if)
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // transaction-level reference state
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t expq [4][$];        // presented by master k=d*2+m, not yet seen on bus
  xfer_t a_x [4], dp_x [4], sdp_x [2];
  bit    a_act [4], dp_act [4], sdp_act [2];
  int    issued [4];
  bit    last_acc [2];
  bit    acc_log [2][$];

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        m_addr[d][m] = '0; m_size[d][m] = 3'd2; m_trans[d][m] = 2'b00;
        m_write[d][m] = 1'b0; m_wdata[d][m] = '0;
      end
      b_ready[d] = 1'b1; b_resp[d] = 1'b0; b_rdata[d] = '0;
    end
  endtask

  task automatic drv(input int m, input logic [31:0] addr, input logic write);
    m_addr[0][m] = addr; m_trans[0][m] = 2'b10; m_write[0][m] = write;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    idle_all();
    next_cycle();
    next_cycle();
    HRESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_act[k] = 0; dp_act[k] = 0; expq[k].delete();
    end
    for (int d = 0; d < 2; d++) begin
      sdp_act[d] = 0; last_acc[d] = 1'b1; acc_log[d].delete();
    end
  endtask

  task automatic run_traffic(input int n, input int gap_pct, input int wait_pct);
    int    cyc_cnt;
    bit    busy;
    bit    both;
    int    d, m, k;
    xfer_t x;
    cyc_cnt = 0;
    busy = 1;
    for (int i = 0; i < 4; i++) issued[i] = 0;
    while (busy && cyc_cnt < 5000) begin
      cyc_cnt++;
      for (int i = 0; i < 2; i++) begin
        b_ready[i] = sdp_act[i] ? (int'($urandom_range(99)) >= wait_pct) : 1'b1;
        b_rdata[i] = sdp_act[i] ? rd_fn(sdp_x[i].addr) : 32'h0;
        b_resp[i]  = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        d = i / 2; m = i % 2;
        if (!a_act[i] && issued[i] < n && int'($urandom_range(99)) >= gap_pct) begin
          a_x[i].addr  = (m == 1 ? 32'h8000_0000 : 32'h0) | 32'(issued[i] * 16) | 32'(d << 12);
          a_x[i].write = 1'($urandom_range(1));
          a_x[i].wdata = $urandom;
          a_act[i] = 1; issued[i]++;
          expq[i].push_back(a_x[i]);
        end
        m_trans[d][m] = a_act[i] ? 2'b10 : 2'b00;
        m_addr[d][m]  = a_act[i] ? a_x[i].addr : 32'h0;
        m_write[d][m] = a_act[i] && a_x[i].write;
        m_wdata[d][m] = (dp_act[i] && dp_x[i].write) ? dp_x[i].wdata : 32'h0;
      end
      #4;
      for (int i = 0; i < 2; i++) begin
        if (b_ready[i]) begin
          if (sdp_act[i]) begin
            if (sdp_x[i].write) chk("bus_wdata", b_wdata[i], sdp_x[i].wdata);
            sdp_act[i] = 0;
          end
          both = expq[2*i].size() > 0 && expq[2*i+1].size() > 0;
          if (expq[2*i].size() > 0 || expq[2*i+1].size() > 0)
            chk("no_idle_with_request", 32'(b_trans[i]), 32'h2);
          if (b_trans[i][1]) begin
            m = int'(b_addr[i][31]); k = 2*i + m;
            chk("not_spurious", 32'(expq[k].size() != 0), 32'h1);
            if (expq[k].size() != 0) begin
              if (both) chk("arb_winner", 32'(m), (i == 0) ? 32'h1 : 32'(!last_acc[i]));
              x = expq[k].pop_front();
              chk("bus_addr", b_addr[i], x.addr);
              chk("bus_write", 32'(b_write[i]), 32'(x.write));
              sdp_x[i] = x; sdp_act[i] = 1;
              last_acc[i] = m[0]; acc_log[i].push_back(m[0]);
            end
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        d = i / 2; m = i % 2;
        if (o_rdy[d][m]) begin
          if (dp_act[i]) begin
            if (!dp_x[i].write) chk("master_rdata", o_rdata[d][m], rd_fn(dp_x[i].addr));
            dp_act[i] = 0;
          end
          if (a_act[i]) begin
            dp_x[i] = a_x[i]; dp_act[i] = 1; a_act[i] = 0;
          end
        end
      end
      busy = sdp_act[0] || sdp_act[1];
      for (int i = 0; i < 4; i++)
        if (issued[i] < n || a_act[i] || dp_act[i] || expq[i].size() != 0) busy = 1;
      next_cycle();
    end
    chk("traffic_drained", 32'(busy), 32'h0);
  endtask

  initial begin
    // reset with both masters driving NONSEQ
    HRESETn = 1'b0;
    idle_all();
    drv(0, 32'h40, 1'b0);
    drv(1, 32'h8000_0040, 1'b0);
    next_cycle();
    next_cycle();
    #4;
    chk("rst_htrans", 32'(b_trans[0]), 32'h0);
    chk("rst_haddr", b_addr[0], 32'h0);
    chk("rst_ifu_hready", 32'(o_rdy[0][0]), 32'h1);
    chk("rst_lsu_hready", 32'(o_rdy[0][1]), 32'h1);
    chk("rst_rr_htrans", 32'(b_trans[1]), 32'h0);
    next_cycle();
    HRESETn = 1'b1;
    idle_all();
    next_cycle();

    // IFU-only read, pass-through
    drv(0, 32'h100, 1'b0);
    #4;
    chk("t2_haddr", b_addr[0], 32'h100);
    chk("t2_htrans", 32'(b_trans[0]), 32'h2);
    next_cycle();
    idle_all();
    b_rdata[0] = 32'h1234_5678;
    #4;
    chk("t2_ifu_rdata", o_rdata[0][0], 32'h1234_5678);
    chk("t2_ifu_hready", 32'(o_rdy[0][0]), 32'h1);
    next_cycle();
    idle_all();

    // fixed priority: LSU write beats IFU read
    drv(0, 32'h200, 1'b0);
    drv(1, 32'h2000_0004, 1'b1);
    #4;
    chk("t3_c0_haddr", b_addr[0], 32'h2000_0004);
    next_cycle();
    idle_all();
    m_wdata[0][1] = 32'hDEAD_BEEF;
    #4;
    chk("t3_c1_haddr", b_addr[0], 32'h200);
    chk("t3_c1_htrans", 32'(b_trans[0]), 32'h2);
    chk("t3_c1_hwdata", b_wdata[0], 32'hDEAD_BEEF);
    chk("t3_c1_ifu_hready", 32'(o_rdy[0][0]), 32'h0);
    next_cycle();
    idle_all();
    #4;
    chk("t3_c2_ifu_hready", 32'(o_rdy[0][0]), 32'h1);
    next_cycle();

    // LSU data phase with 3 wait states while IFU requests 0x300
    drv(1, 32'h2000_0010, 1'b0);
    #4;
    next_cycle();
    idle_all();
    drv(0, 32'h300, 1'b0);
    b_ready[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("t5_htrans_stable", 32'(b_trans[0]), 32'h0);
      chk("t5_haddr_stable", b_addr[0], 32'h0);
      chk("t5_lsu_hready", 32'(o_rdy[0][1]), 32'h0);
      chk("t5_ifu_hready", 32'(o_rdy[0][0]), (c == 0) ? 32'h1 : 32'h0);
      next_cycle();
      m_trans[0][0] = 2'b00; m_addr[0][0] = 32'h0;
    end
    b_ready[0] = 1'b1;
    #4;
    chk("t5_ifu_issued_addr", b_addr[0], 32'h300);
    chk("t5_ifu_issued_trans", 32'(b_trans[0]), 32'h2);
    next_cycle();
    #4;
    chk("t5_ifu_done", 32'(o_rdy[0][0]), 32'h1);
    next_cycle();

    // ERROR response on LSU while IFU is held
    drv(0, 32'h400, 1'b0);
    drv(1, 32'h2000_0020, 1'b0);
    #4;
    chk("t6_lsu_first", b_addr[0], 32'h2000_0020);
    next_cycle();
    idle_all();
    b_ready[0] = 1'b0; b_resp[0] = 1'b1;
    #4;
    chk("t6_e1_lsu_hresp", 32'(o_resp[0][1]), 32'h1);
    chk("t6_e1_ifu_hresp", 32'(o_resp[0][0]), 32'h0);
    chk("t6_e1_lsu_hready", 32'(o_rdy[0][1]), 32'h0);
    next_cycle();
    b_ready[0] = 1'b1; b_resp[0] = 1'b1;
    #4;
    chk("t6_e2_lsu_hresp", 32'(o_resp[0][1]), 32'h1);
    chk("t6_e2_ifu_hresp", 32'(o_resp[0][0]), 32'h0);
    chk("t6_e2_ifu_issued", b_addr[0], 32'h400);
    next_cycle();
    b_resp[0] = 1'b0;
    #4;
    chk("t6_ifu_done", 32'(o_rdy[0][0]), 32'h1);
    next_cycle();

    // reset while IFU is held discards the hold
    drv(0, 32'h500, 1'b0);
    drv(1, 32'h2000_0030, 1'b0);
    #4;
    next_cycle();
    idle_all();
    #4;
    chk("t6_ifu_pending", 32'(o_rdy[0][0]), 32'h0);
    HRESETn = 1'b0;
    next_cycle();
    HRESETn = 1'b1;
    #4;
    chk("t6_rst_ifu_hready", 32'(o_rdy[0][0]), 32'h1);
    chk("t6_rst_htrans", 32'(b_trans[0]), 32'h0);
    next_cycle();

    // back-to-back contention: round-robin must alternate IFU, LSU, ...
    do_reset();
    run_traffic(3, 0, 0);
    chk("t4_rr_count", 32'(acc_log[1].size()), 32'h6);
    for (int i = 0; i < 6 && i < acc_log[1].size(); i++)
      chk("t4_rr_order", 32'(acc_log[1][i]), 32'(i % 2));

    // randomized gaps and wait states on both instances
    run_traffic(40, 30, 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
